// File: rtl/b06_eql_arbiter.sv
// b06_eql_arbiter: round-robin front end that lets NREQ requesters share one
// b06-style interrupt-handler FSM. A winner gets a one-hot GNT, the handler
// sees a one-cycle EQL pulse (with CONT_EQL held from the winner's CONT_REQ),
// and the winner receives a one-cycle DONE once the handler answers ACKOUT.
// All outputs are registered.
// Optional feature macro: B06_ARB_TIMEOUT_EN adds an ACK watchdog that aborts
// a transaction with a one-cycle ERR after TMO_MAX unanswered WAIT_ACK cycles.
module b06_eql_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic            clock,
  input  logic            RESET_G,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] CONT_REQ,
  input  logic            ACKOUT_I,
  output logic [NREQ-1:0] GNT,
  output logic [ID_W-1:0] GNT_ID,
  output logic [NREQ-1:0] DONE,
  output logic            EQL_O,
  output logic            CONT_EQL_O,
  output logic            ERR
);

  if (NREQ < 2 || NREQ > 8 || (2 ** ID_W) < NREQ ||
      TMO_MAX < 1 || TMO_MAX > (2 ** TMO_W) - 1) begin : g_param_check
    $error("b06_eql_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT_ACK,
    S_RELEASE
  } state_t;

  state_t          state, state_d;
  logic [ID_W-1:0] rr_ptr, rr_ptr_d;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            tmo_hit;

  logic [NREQ-1:0] gnt_d;
  logic [ID_W-1:0] gnt_id_d;
  logic [NREQ-1:0] done_d;
  logic            eql_d;
  logic            cont_d;
  logic            err_d;

`ifdef B06_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] wdog, wdog_d;

  // Watchdog expires on the WAIT_ACK cycle that would make it reach TMO_MAX
  assign tmo_hit = (wdog == TMO_W'(TMO_MAX - 1));

  // Watchdog register: cleared on WAIT_ACK entry, counts unanswered cycles
  always_comb begin
    wdog_d = wdog;
    if (state == S_DRIVE)
      wdog_d = '0;
    else if (state == S_WAIT_ACK && !ACKOUT_I && !tmo_hit)
      wdog_d = wdog + TMO_W'(1);
  end

  // Watchdog storage
  always_ff @(posedge clock or posedge RESET_G) begin
    if (RESET_G) wdog <= '0;
    else         wdog <= wdog_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Round-robin search: first requester at or above rr_ptr, wrapping at NREQ
  always_comb begin
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clock or posedge RESET_G) begin
    if (RESET_G) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (win_found) state_d = S_DRIVE;
      S_DRIVE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (ACKOUT_I || tmo_hit) state_d = S_RELEASE;
      S_RELEASE:  if (!REQ[GNT_ID]) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the rr pointer
  always_comb begin
    gnt_d    = GNT;
    gnt_id_d = GNT_ID;
    cont_d   = CONT_EQL_O;
    done_d   = '0;
    eql_d    = 1'b0;
    err_d    = 1'b0;
    rr_ptr_d = rr_ptr;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          gnt_d    = NREQ'(1) << win_id;
          gnt_id_d = win_id;
          cont_d   = CONT_REQ[win_id];
          eql_d    = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        // An ACK arriving on the expiry cycle takes priority over the timeout
        if (ACKOUT_I) begin
          done_d = GNT;
          gnt_d  = '0;
          cont_d = 1'b0;
        end else if (tmo_hit) begin
          err_d  = 1'b1;
          gnt_d  = '0;
          cont_d = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!REQ[GNT_ID])
          rr_ptr_d = (32'(GNT_ID) == 32'(NREQ - 1)) ? '0 : GNT_ID + ID_W'(1);
      end
      default: ;
    endcase
  end

  // Output and pointer registers
  always_ff @(posedge clock or posedge RESET_G) begin
    if (RESET_G) begin
      GNT        <= '0;
      GNT_ID     <= '0;
      DONE       <= '0;
      EQL_O      <= 1'b0;
      CONT_EQL_O <= 1'b0;
      ERR        <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      GNT        <= gnt_d;
      GNT_ID     <= gnt_id_d;
      DONE       <= done_d;
      EQL_O      <= eql_d;
      CONT_EQL_O <= cont_d;
      ERR        <= err_d;
      rr_ptr     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_b06_eql_arbiter.sv
// Bench for b06_eql_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a transaction-level
// model of the arbitration rules. Honours B06_ARB_TIMEOUT_EN like the design.
module tb_b06_eql_arbiter;
  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = 15;

  logic            clock   = 1'b0;
  logic            RESET_G = 1'b1;
  logic [NREQ-1:0] REQ     = '0;
  logic [NREQ-1:0] CONT_REQ = '0;
  logic            ACKOUT_I = 1'b0;
  logic [NREQ-1:0] GNT, DONE;
  logic [ID_W-1:0] GNT_ID;
  logic            EQL_O, CONT_EQL_O, ERR;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  b06_eql_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .clock(clock), .RESET_G(RESET_G), .REQ(REQ), .CONT_REQ(CONT_REQ),
    .ACKOUT_I(ACKOUT_I), .GNT(GNT), .GNT_ID(GNT_ID), .DONE(DONE),
    .EQL_O(EQL_O), .CONT_EQL_O(CONT_EQL_O), .ERR(ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int              m_owner;   // requester currently served, -1 if none
  int              m_last;    // last granted requester
  int              m_ptr;     // round-robin start point
  int              m_unacked; // WAIT_ACK cycles seen without an ACK
  bit              m_in_eql;  // grant issued, EQL cycle in progress
  bit              m_release; // finished, waiting for the requester to let go
  int              m_skip[NREQ]; // grants given to others while pending
  logic [NREQ-1:0] e_gnt, e_done;
  logic [ID_W-1:0] e_id;
  logic            e_eql, e_cont, e_err;

  task automatic m_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_unacked = 0;
    m_in_eql = 0; m_release = 0;
    for (int i = 0; i < NREQ; i++) m_skip[i] = 0;
    e_gnt = '0; e_done = '0; e_id = '0; e_eql = 0; e_cont = 0; e_err = 0;
  endtask

  task automatic m_finish();
    e_gnt = '0; e_cont = 0; m_owner = -1; m_release = 1;
  endtask

  task automatic m_step();
    e_done = '0; e_err = 0; e_eql = 0;
    for (int i = 0; i < NREQ; i++) if (!REQ[i]) m_skip[i] = 0;
    if (m_release) begin
      if (!REQ[m_last]) begin
        m_release = 0;
        m_ptr = (m_last + 1) % NREQ;
      end
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (m_owner < 0 && REQ[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        chk("starve", m_skip[m_owner] <= NREQ - 1, 1);
        for (int i = 0; i < NREQ; i++)
          if (i != m_owner && REQ[i]) m_skip[i]++;
        m_skip[m_owner] = 0;
        m_last = m_owner;
        e_gnt = NREQ'(1) << m_owner;
        e_id = ID_W'(m_owner);
        e_cont = CONT_REQ[m_owner];
        e_eql = 1;
        m_in_eql = 1;
      end
    end else if (m_in_eql) begin
      m_in_eql = 0;
      m_unacked = 0;
    end else if (ACKOUT_I) begin
      e_done = NREQ'(1) << m_owner;
      m_finish();
    end else begin
      m_unacked++;
`ifdef B06_ARB_TIMEOUT_EN
      if (m_unacked == TMO_MAX) begin
        e_err = 1;
        m_finish();
      end
`endif
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or posedge RESET_G);
      if (RESET_G) m_reset();
      else         m_step();
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clock) begin
    int n;
    if (!RESET_G) begin
      chk("gnt", GNT, e_gnt);
      chk("gnt_id", GNT_ID, e_id);
      chk("done", DONE, e_done);
      chk("eql", EQL_O, e_eql);
      chk("cont_eql", CONT_EQL_O, e_cont);
      chk("err", ERR, e_err);
      n = (|GNT) + (|DONE) + ERR;
      chk("exclusive", n <= 1, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    RESET_G = 1'b1;
    step(); step();
    RESET_G = 1'b0;
  endtask

  // Acknowledge everything until all requests have been served and released
  task automatic drain();
    bit ok;
    ok = 0;
    ACKOUT_I = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (DONE[i]) REQ[i] = 1'b0;
      ok = (REQ == '0) && (GNT == '0) && (DONE == '0);
    end
    chk("drain_done", ok, 1);
    ACKOUT_I = 1'b0;
    step(); step();
  endtask

  // Wait (bounded) until DONE for requester idx is visible
  task automatic wait_done(input int idx);
    bit seen;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      step();
      seen = DONE[idx];
    end
    chk("wait_done", seen, 1);
  endtask

  int order[$];
  int exp_order[6] = '{0, 1, 2, 3, 0, 3};
  bit served[NREQ];

  initial begin
    step(); step();
    RESET_G = 1'b0;

    // 1: idle after reset
    repeat (10) begin
      step();
      chk("t1_gnt", GNT, 0); chk("t1_eql", EQL_O, 0);
      chk("t1_err", ERR, 0); chk("t1_id", GNT_ID, 0);
    end

    // 2: single requester
    REQ = 4'b0100; CONT_REQ = 4'b0100;
    step();
    chk("t2_gnt", GNT, 4'b0100); chk("t2_eql", EQL_O, 1);
    chk("t2_id", GNT_ID, 2); chk("t2_cont", CONT_EQL_O, 1);
    repeat (3) begin
      step();
      chk("t2_eql_low", EQL_O, 0); chk("t2_cont_hold", CONT_EQL_O, 1);
      chk("t2_done_low", DONE, 0);
    end
    ACKOUT_I = 1'b1;
    step();
    chk("t2_done", DONE, 4'b0100); chk("t2_gnt_clr", GNT, 0);
    chk("t2_cont_clr", CONT_EQL_O, 0);
    ACKOUT_I = 1'b0; REQ = '0; CONT_REQ = '0;
    step();
    chk("t2_done_pulse", DONE, 0);
    step();

    // 3: round-robin order
    do_reset();
    REQ = 4'b1111;
    drain_rec();
    REQ = 4'b1001;
    drain_rec();
    chk("t3_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk("t3_order", order[i], exp_order[i]);

    // 4: async reset during WAIT_ACK
    REQ = 4'b0001; ACKOUT_I = 1'b1;
    wait_done(0);
    REQ = '0; ACKOUT_I = 1'b0;
    step(); step(); step();
    REQ = 4'b0100;
    step(); step(); step();
    chk("t4_pre_gnt", GNT, 4'b0100);
    #2 RESET_G = 1'b1;
    #1;
    chk("t4_gnt", GNT, 0); chk("t4_id", GNT_ID, 0); chk("t4_done", DONE, 0);
    chk("t4_eql", EQL_O, 0); chk("t4_cont", CONT_EQL_O, 0); chk("t4_err", ERR, 0);
    REQ = 4'b0011;
    step();
    RESET_G = 1'b0;
    step();
    chk("t4_ptr_reset", GNT, 4'b0001);
    drain();

    // 6: new request arriving together with DONE waits for RELEASE exit
    REQ = 4'b0001; ACKOUT_I = 1'b1;
    wait_done(0);
    REQ = 4'b0011; ACKOUT_I = 1'b0;
    step();
    chk("t6_hold", GNT, 0);
    REQ = 4'b0010;
    step();
    chk("t6_idle_gap", GNT, 0);
    step();
    chk("t6_gnt", GNT, 4'b0010); chk("t6_id", GNT_ID, 1);
    drain();

    // 5: watchdog
`ifdef B06_ARB_TIMEOUT_EN
    REQ = 4'b0001;
    step();
    chk("t5_eql", EQL_O, 1);
    repeat (TMO_MAX) begin
      step();
      chk("t5_no_err_yet", ERR, 0); chk("t5_no_done", DONE, 0);
    end
    step();
    chk("t5_err", ERR, 1); chk("t5_err_done", DONE, 0); chk("t5_err_gnt", GNT, 0);
    REQ = '0;
    step();
    chk("t5_err_pulse", ERR, 0);
    step(); step();
    REQ = 4'b0001;
    step();
    repeat (TMO_MAX) step();
    ACKOUT_I = 1'b1;
    step();
    chk("t5_ack_wins_done", DONE, 4'b0001); chk("t5_ack_wins_err", ERR, 0);
    ACKOUT_I = 1'b0; REQ = '0;
    step(); step(); step();
`else
    REQ = 4'b0001;
    repeat (100) begin
      step();
      chk("t5_no_err", ERR, 0); chk("t5_gnt_held", GNT, 4'b0001);
    end
    drain();
`endif

    // Randomized phase
    REQ = '0;
    for (int i = 0; i < NREQ; i++) served[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 1500) begin
        RESET_G = 1'b1;
        #2 RESET_G = 1'b0;
        for (int i = 0; i < NREQ; i++) served[i] = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (e_done[i] || (e_err && e_id == ID_W'(i))) served[i] = 1;
        if (REQ[i]) begin
          if (served[i] && $urandom_range(0, 2) == 0) begin
            REQ[i] = 1'b0;
            served[i] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          REQ[i] = 1'b1;
        end
      end
      CONT_REQ = NREQ'($urandom);
      ACKOUT_I = ($urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Serve all raised requests with immediate ACKs, recording the grant order
  task automatic drain_rec();
    ACKOUT_I = 1'b1;
    for (int n = 0; n < 200 && (REQ != '0 || GNT != '0); n++) begin
      step();
      if (EQL_O) order.push_back(int'(GNT_ID));
      for (int i = 0; i < NREQ; i++) if (DONE[i]) REQ[i] = 1'b0;
    end
    ACKOUT_I = 1'b0;
    step(); step();
  endtask

endmodule
